// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the memory-stage data-access engine:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 3 is treated as word)
//   - access FSM state type (IDLE / REQ / DONE)
//   - calc_be(): byte-enable generation from size and byte offset
// -----------------------------------------------------------------------------
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Little-endian lanes: lane i covers bits [8i+7:8i] of the memory word.
    function automatic logic [3:0] calc_be(input logic [1:0] size,
                                           input logic [1:0] off);
        case (size)
            SZ_BYTE: calc_be = 4'b0001 << off;
            SZ_HALF: calc_be = 4'b0011 << {off[1], 1'b0};
            default: calc_be = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Purely combinational load formatter: picks the byte/half/word addressed by
// the low address bits out of the memory word and zero- or sign-extends it.
// Ports:
//   rdata     in  32  raw memory read word
//   addr      in  2   byte offset within the word
//   size      in  2   access size (byte / half / word; 3 = word)
//   is_signed in  1   1 = sign-extend, 0 = zero-extend
//   data_out  out 32  aligned, extended load value
// -----------------------------------------------------------------------------
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data_out
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addr)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
    end

    // Halves are only ever naturally aligned, so addr[1] alone picks the lane.
    assign w_half = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (size)
            SZ_BYTE: data_out = {{24{is_signed & w_byte[7]}}, w_byte};
            SZ_HALF: data_out = {{16{is_signed & w_half[15]}}, w_half};
            default: data_out = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage data-access engine. Takes the load/store held in EX/MEM, runs a
// req/ack transaction on the data memory, and returns the aligned, extended
// load result in ReadData. Stalls the pipeline until the access completes and
// flags misaligned accesses (misalign) and ack timeouts (bus_err).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   EM_MemRead / EM_MemWrite   load / store request (store wins)
//   EM_ALUResult  [31:0]       byte address
//   EM_WriteData  [31:0]       right-justified store data
//   EM_MemSize    [1:0]        0 byte, 1 half, 2/3 word
//   EM_MemSigned               sign-extend loads
//   ReadData      [31:0]       registered load result
//   mem_stall                  combinational pipeline freeze
//   misalign, bus_err          one-cycle registered pulses
//   mem_req, mem_we, mem_addr[29:0], mem_be[3:0], mem_wdata[31:0]
//                              data-memory request side (registered)
//   mem_ack, mem_rdata[31:0]   data-memory response side
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EM_MemRead,
    input  logic        EM_MemWrite,
    input  logic [31:0] EM_ALUResult,
    input  logic [31:0] EM_WriteData,
    input  logic [1:0]  EM_MemSize,
    input  logic        EM_MemSigned,
    output logic [31:0] ReadData,
    output logic        mem_stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    // Last wait-count value before the abort; the abort edge is the one on
    // which the counter would reach TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic             r_misalign;
    logic             r_bus_err;
    logic             r_req;
    logic             r_we;
    logic [29:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [1:0]       r_off;
    logic [1:0]       r_size;
    logic             r_signed;

    logic             w_valid;
    logic             w_misalign;
    logic [31:0]      w_wdata;
    logic [31:0]      w_ld;

    assign w_valid = EM_MemRead | EM_MemWrite;

    always_comb begin
        case (EM_MemSize)
            SZ_BYTE: w_misalign = 1'b0;
            SZ_HALF: w_misalign = EM_ALUResult[0];
            default: w_misalign = (EM_ALUResult[1:0] != 2'b00);
        endcase
    end

    // Replicate store data across lanes so the byte enables alone pick the target.
    always_comb begin
        case (EM_MemSize)
            SZ_BYTE: w_wdata = {4{EM_WriteData[7:0]}};
            SZ_HALF: w_wdata = {2{EM_WriteData[15:0]}};
            default: w_wdata = EM_WriteData;
        endcase
    end

    load_align u_load_align (
        .rdata     (mem_rdata),
        .addr      (r_off),
        .size      (r_size),
        .is_signed (r_signed),
        .data_out  (w_ld)
    );

    // Stall is asserted in the request-issue cycle already so EX/MEM holds
    // the instruction until the DONE cycle, where MEM/WB samples ReadData.
    assign mem_stall = ((r_state == IDLE) && w_valid && !w_misalign) ||
                       (r_state == REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_off      <= '0;
            r_size     <= '0;
            r_signed   <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        if (w_misalign) begin
                            r_misalign <= 1'b1;
                            r_rdata    <= '0;
                        end else begin
                            r_we     <= EM_MemWrite;
                            r_addr   <= EM_ALUResult[31:2];
                            r_be     <= calc_be(EM_MemSize, EM_ALUResult[1:0]);
                            r_wdata  <= w_wdata;
                            r_off    <= EM_ALUResult[1:0];
                            r_size   <= EM_MemSize;
                            r_signed <= EM_MemSigned;
                            r_req    <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= REQ;
                        end
                    end
                end
                REQ: begin
                    // Ack is checked first so an ack on the final wait cycle
                    // still completes normally.
                    if (mem_ack) begin
                        r_req   <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= w_ld;
                        end
                        r_state <= DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_rdata   <= '0;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ReadData  = r_rdata;
    assign misalign  = r_misalign;
    assign bus_err   = r_bus_err;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit: inputs are driven 1 ns after the rising
// edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        EM_MemRead;
    logic        EM_MemWrite;
    logic [31:0] EM_ALUResult;
    logic [31:0] EM_WriteData;
    logic [1:0]  EM_MemSize;
    logic        EM_MemSigned;
    logic [31:0] ReadData;
    logic        mem_stall;
    logic        misalign;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_pass;
    int n_total;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .EM_MemRead   (EM_MemRead),
        .EM_MemWrite  (EM_MemWrite),
        .EM_ALUResult (EM_ALUResult),
        .EM_WriteData (EM_WriteData),
        .EM_MemSize   (EM_MemSize),
        .EM_MemSigned (EM_MemSigned),
        .ReadData     (ReadData),
        .mem_stall    (mem_stall),
        .misalign     (misalign),
        .bus_err      (bus_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus driver for one access whose EM_* inputs are already applied.
    // Called just after a rising edge; returns at the falling edge of the
    // first non-stall cycle (DONE). ack_at = index of the REQ cycle that gets
    // mem_ack (negative = never). Captures request-side signals seen in REQ.
    task automatic do_access(input int ack_at, input logic [31:0] rd,
                             output int stalls, output bit done,
                             output logic [29:0] c_addr, output logic [3:0] c_be,
                             output logic [31:0] c_wdata, output logic c_we);
        int reqcyc;
        stalls = 0;
        reqcyc = 0;
        done   = 1'b0;
        c_addr = '0; c_be = '0; c_wdata = '0; c_we = 1'b0;
        mem_ack = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (mem_req) begin
                if (reqcyc == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
                reqcyc++;
            end
            @(negedge clk);
            if (!mem_stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            if (mem_req) begin
                c_addr = mem_addr; c_be = mem_be; c_wdata = mem_wdata; c_we = mem_we;
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
    endtask

    task automatic set_access(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [1:0] size, input logic sgn);
        EM_MemRead   = rd_en;
        EM_MemWrite  = wr_en;
        EM_ALUResult = addr;
        EM_WriteData = wd;
        EM_MemSize   = size;
        EM_MemSigned = sgn;
    endtask

    // Pipeline advances past DONE: remove the request after the next edge.
    task automatic end_access();
        @(posedge clk);
        #1;
        EM_MemRead  = 1'b0;
        EM_MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (ReadData !== 32'h0) $display("FAIL reset_ReadData got %h want 0", ReadData); else n_pass++;
        n_total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", mem_req); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we); else n_pass++;
        n_total++; if (misalign !== 1'b0) $display("FAIL reset_misalign got %b want 0", misalign); else n_pass++;
        n_total++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err got %b want 0", bus_err); else n_pass++;
        n_total++; if (mem_be !== 4'h0) $display("FAIL reset_mem_be got %h want 0", mem_be); else n_pass++;
        n_total++; if (mem_addr !== 30'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else n_pass++;
        n_total++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); else n_pass++;
        n_total++; if (mem_stall !== 1'b0) $display("FAIL reset_mem_stall got %b want 0", mem_stall); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_word();
        int st; bit dn; logic [29:0] a; logic [3:0] be; logic [31:0] wd; logic we;
        set_access(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        do_access(0, 32'h89ABCDEF, st, dn, a, be, wd, we);
        n_total++; if (!dn) $display("FAIL lw_done never left stall"); else n_pass++;
        n_total++; if (st != 2) $display("FAIL lw_stalls got %0d want 2", st); else n_pass++;
        n_total++; if (ReadData !== 32'h89ABCDEF) $display("FAIL lw_ReadData got %h want 89abcdef", ReadData); else n_pass++;
        n_total++; if (a !== 30'h40) $display("FAIL lw_mem_addr got %h want 40", a); else n_pass++;
        n_total++; if (be !== 4'hF) $display("FAIL lw_mem_be got %h want f", be); else n_pass++;
        n_total++; if (we !== 1'b0) $display("FAIL lw_mem_we got %b want 0", we); else n_pass++;
        n_total++; if (mem_req !== 1'b0) $display("FAIL lw_req_done got %b want 0", mem_req); else n_pass++;
        end_access();
        @(negedge clk);
        n_total++; if (mem_req !== 1'b0 || mem_stall !== 1'b0) $display("FAIL lw_no_reissue got req=%b stall=%b want 0/0", mem_req, mem_stall); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_load_sub();
        int st; bit dn; logic [29:0] a; logic [3:0] be; logic [31:0] wd; logic we;
        set_access(1'b1, 1'b0, 32'h103, 32'h0, 2'd0, 1'b1);
        do_access(0, 32'h80112233, st, dn, a, be, wd, we);
        n_total++; if (be !== 4'b1000) $display("FAIL lb_s_be got %b want 1000", be); else n_pass++;
        n_total++; if (ReadData !== 32'hFFFFFF80) $display("FAIL lb_s_ReadData got %h want ffffff80", ReadData); else n_pass++;
        end_access();
        set_access(1'b1, 1'b0, 32'h103, 32'h0, 2'd0, 1'b0);
        do_access(0, 32'h80112233, st, dn, a, be, wd, we);
        n_total++; if (ReadData !== 32'h00000080) $display("FAIL lbu_ReadData got %h want 00000080", ReadData); else n_pass++;
        end_access();
        set_access(1'b1, 1'b0, 32'h102, 32'h0, 2'd1, 1'b1);
        do_access(0, 32'h80112233, st, dn, a, be, wd, we);
        n_total++; if (be !== 4'b1100) $display("FAIL lh_s_be got %b want 1100", be); else n_pass++;
        n_total++; if (ReadData !== 32'hFFFF8011) $display("FAIL lh_s_ReadData got %h want ffff8011", ReadData); else n_pass++;
        end_access();
        set_access(1'b1, 1'b0, 32'h101, 32'h0, 2'd0, 1'b0);
        do_access(0, 32'h80112233, st, dn, a, be, wd, we);
        n_total++; if (be !== 4'b0010) $display("FAIL lbu1_be got %b want 0010", be); else n_pass++;
        n_total++; if (ReadData !== 32'h00000022) $display("FAIL lbu1_ReadData got %h want 00000022", ReadData); else n_pass++;
        end_access();
    endtask

    task automatic test_store();
        int st; bit dn; logic [29:0] a; logic [3:0] be; logic [31:0] wd; logic we;
        // Both requests high: the store takes priority.
        set_access(1'b1, 1'b1, 32'h202, 32'h1234ABCD, 2'd1, 1'b0);
        do_access(0, 32'hDEADBEEF, st, dn, a, be, wd, we);
        n_total++; if (we !== 1'b1) $display("FAIL sh_mem_we got %b want 1", we); else n_pass++;
        n_total++; if (be !== 4'b1100) $display("FAIL sh_mem_be got %b want 1100", be); else n_pass++;
        n_total++; if (wd !== 32'hABCDABCD) $display("FAIL sh_mem_wdata got %h want abcdabcd", wd); else n_pass++;
        n_total++; if (a !== 30'h80) $display("FAIL sh_mem_addr got %h want 80", a); else n_pass++;
        n_total++; if (ReadData !== 32'h00000022) $display("FAIL sh_ReadData got %h want 00000022", ReadData); else n_pass++;
        end_access();
        set_access(1'b0, 1'b1, 32'h201, 32'h000000A5, 2'd0, 1'b0);
        do_access(2, 32'h0, st, dn, a, be, wd, we);
        n_total++; if (st != 4) $display("FAIL sb_wait2_stalls got %0d want 4", st); else n_pass++;
        n_total++; if (be !== 4'b0010) $display("FAIL sb_mem_be got %b want 0010", be); else n_pass++;
        n_total++; if (wd !== 32'hA5A5A5A5) $display("FAIL sb_mem_wdata got %h want a5a5a5a5", wd); else n_pass++;
        end_access();
    endtask

    task automatic test_misalign();
        set_access(1'b1, 1'b0, 32'h101, 32'h0, 2'd2, 1'b0);
        @(negedge clk);
        n_total++; if (mem_stall !== 1'b0) $display("FAIL mis_stall got %b want 0", mem_stall); else n_pass++;
        @(posedge clk); #1;
        EM_MemRead = 1'b0;
        @(negedge clk);
        n_total++; if (misalign !== 1'b1) $display("FAIL mis_pulse got %b want 1", misalign); else n_pass++;
        n_total++; if (mem_req !== 1'b0) $display("FAIL mis_req got %b want 0", mem_req); else n_pass++;
        n_total++; if (ReadData !== 32'h0) $display("FAIL mis_ReadData got %h want 0", ReadData); else n_pass++;
        @(negedge clk);
        n_total++; if (misalign !== 1'b0) $display("FAIL mis_one_pulse got %b want 0", misalign); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int st; bit dn; logic [29:0] a; logic [3:0] be; logic [31:0] wd; logic we;
        // Ack on the 16th REQ cycle: same cycle the counter would abort.
        set_access(1'b1, 1'b0, 32'h300, 32'h0, 2'd2, 1'b0);
        do_access(15, 32'h13579BDF, st, dn, a, be, wd, we);
        n_total++; if (st != 17) $display("FAIL late_ack_stalls got %0d want 17", st); else n_pass++;
        n_total++; if (bus_err !== 1'b0) $display("FAIL late_ack_bus_err got %b want 0", bus_err); else n_pass++;
        n_total++; if (ReadData !== 32'h13579BDF) $display("FAIL late_ack_ReadData got %h want 13579bdf", ReadData); else n_pass++;
        end_access();
        set_access(1'b1, 1'b0, 32'h300, 32'h0, 2'd2, 1'b0);
        do_access(-1, 32'h0, st, dn, a, be, wd, we);
        n_total++; if (!dn) $display("FAIL to_done never left stall"); else n_pass++;
        n_total++; if (st != 17) $display("FAIL to_stalls got %0d want 17", st); else n_pass++;
        n_total++; if (bus_err !== 1'b1) $display("FAIL to_bus_err got %b want 1", bus_err); else n_pass++;
        n_total++; if (mem_req !== 1'b0) $display("FAIL to_req got %b want 0", mem_req); else n_pass++;
        n_total++; if (ReadData !== 32'h0) $display("FAIL to_ReadData got %h want 0", ReadData); else n_pass++;
        end_access();
        @(negedge clk);
        n_total++; if (bus_err !== 1'b0) $display("FAIL to_one_pulse got %b want 0", bus_err); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_req();
        int st; bit dn; logic [29:0] a; logic [3:0] be; logic [31:0] wd; logic we;
        set_access(1'b1, 1'b0, 32'h400, 32'h0, 2'd2, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_total++; if (mem_req !== 1'b1) $display("FAIL rst_pre_req got %b want 1", mem_req); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL rst_async_req got %b want 0", mem_req); else n_pass++;
        EM_MemRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        n_total++; if (mem_req !== 1'b0 || mem_stall !== 1'b0) $display("FAIL rst_late_ack got req=%b stall=%b want 0/0", mem_req, mem_stall); else n_pass++;
        n_total++; if (ReadData !== 32'h0) $display("FAIL rst_late_ack_ReadData got %h want 0", ReadData); else n_pass++;
        @(posedge clk); #1;
        set_access(1'b1, 1'b0, 32'h500, 32'h0, 2'd2, 1'b0);
        do_access(0, 32'hCAFEF00D, st, dn, a, be, wd, we);
        n_total++; if (st != 2) $display("FAIL rst_next_stalls got %0d want 2", st); else n_pass++;
        n_total++; if (ReadData !== 32'hCAFEF00D) $display("FAIL rst_next_ReadData got %h want cafef00d", ReadData); else n_pass++;
        n_total++; if (a !== 30'h140) $display("FAIL rst_next_addr got %h want 140", a); else n_pass++;
        end_access();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        set_access(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        test_reset();
        test_load_word();
        test_load_sub();
        test_store();
        test_misalign();
        test_timeout();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
